// File: rtl/sc_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sc_mul_pkg
// Purpose : Shared types, mode constants and the RNG bit-reversal helper for
//           the stochastic-computing multiply/accumulate block.
// Revision: 1.0 - initial release
// ============================================================================
package sc_mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_UNI = 1'b0;
  localparam logic MODE_BI  = 1'b1;

  // Reverse the low W bits of V; bits at and above W come back as zero.
  // Reversing a plain counter gives a van der Corput sequence, which spreads
  // the compare thresholds evenly over the window.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) r[w-1-i] = v[i];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sc_cmp.sv
`default_nettype none
// ============================================================================
// Module  : sc_cmp
// Purpose : Unsigned strict greater-than comparator (oGt = iA > iB).
// Revision: 1.0 - initial release
// ============================================================================
module sc_cmp #(
  parameter int IWID = 8
) (
  input  logic [IWID-1:0] iA,
  input  logic [IWID-1:0] iB,
  output logic            oGt
);

  assign oGt = (iA > iB);

endmodule
`default_nettype wire

// File: rtl/sc_mul_acc.sv
`default_nettype none
// ============================================================================
// Module  : sc_mul_acc
// Purpose : Multi-channel stochastic multiplier. One iStart runs a window of
//           2^IWID cycles; each channel ANDs (unipolar) or muxes (bipolar)
//           its data bitstream against a weight stream derived from a shared
//           bit-reversed counter, and counts the product ones.
// Revision: 1.0 - initial release
// ============================================================================
module sc_mul_acc
  import sc_mul_pkg::*;
#(
  parameter int IWID = 8,
  parameter int NCH  = 4,
  parameter int CWID = IWID + 1
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iStart,
  input  logic                iMode,
  input  logic [NCH*IWID-1:0] iWeig,
  input  logic [NCH-1:0]      iDbit,
  input  logic [NCH-1:0]      iDb_n,
  output logic [NCH-1:0]      oDbit,
  output logic                oValid,
  output logic                oBusy,
  output logic                oDone,
  output logic [NCH*CWID-1:0] oCnt
);

  state_t                         state_q;
  logic [IWID-1:0]                cnt_q;
  logic [NCH-1:0][IWID-1:0]       weig_q;
  logic                           mode_q;
  logic [NCH-1:0][CWID-1:0]       acc_q;
  logic [NCH-1:0][CWID-1:0]       acc_d;
  logic [NCH-1:0][CWID-1:0]       cnt_out_q;
  logic [NCH-1:0]                 dbit_q;
  logic                           valid_q;
  logic                           busy_q;
  logic                           done_q;

  logic [IWID-1:0]                w_rng;
  logic [IWID-1:0]                w_rng_n;
  logic [NCH-1:0]                 w_bit;
  logic [NCH-1:0]                 w_b_n;
  logic [NCH-1:0]                 w_prod;
  logic                           w_run;
  logic                           w_last;

  assign w_run   = (state_q == ST_RUN);
  assign w_last  = &cnt_q;
  assign w_rng   = IWID'(bitrev(32'(cnt_q), IWID));
  assign w_rng_n = ~w_rng;

  generate
    for (genvar c = 0; c < NCH; c++) begin : g_ch
      sc_cmp #(.IWID(IWID)) u_cmp_p (
        .iA  (weig_q[c]),
        .iB  (w_rng),
        .oGt (w_bit[c])
      );

      sc_cmp #(.IWID(IWID)) u_cmp_n (
        .iA  (weig_q[c]),
        .iB  (w_rng_n),
        .oGt (w_b_n[c])
      );

      // Bipolar mode draws from the complementary stream on the inverted
      // threshold so that the two coded halves cover the window together.
      assign w_prod[c] = w_run & ((mode_q == MODE_BI)
                       ? ((iDbit[c] & w_bit[c]) | (iDb_n[c] & ~w_b_n[c]))
                       : (iDbit[c] & w_bit[c]));

      // Cannot overflow: at most 2^IWID increments into CWID >= IWID+1 bits.
      assign acc_d[c] = acc_q[c] + CWID'(w_prod[c]);
    end
  endgenerate

  // Window sequencing: latch operands on start, step RNG and accumulators in RUN,
  // publish counts on the final RUN edge.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      weig_q    <= '0;
      mode_q    <= MODE_UNI;
      acc_q     <= '0;
      cnt_out_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (iStart) begin
            state_q <= ST_RUN;
            weig_q  <= iWeig;
            mode_q  <= iMode;
            cnt_q   <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          cnt_q <= cnt_q + 1'b1;
          acc_q <= acc_d;
          if (w_last) begin
            state_q   <= ST_DONE;
            cnt_out_q <= acc_d;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Product bitstream register: one cycle behind the combinational product.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      dbit_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      dbit_q  <= w_run ? w_prod : '0;
      valid_q <= w_run;
    end
  end

  assign oDbit  = dbit_q;
  assign oValid = valid_q;
  assign oBusy  = busy_q;
  assign oDone  = done_q;
  assign oCnt   = cnt_out_q;

endmodule
`default_nettype wire

// File: tb/tb_sc_mul_acc.sv
`default_nettype none
// ============================================================================
// Module  : tb_sc_mul_acc
// Purpose : Self-checking bench for sc_mul_acc (IWID=8, NCH=4, CWID=9).
// Revision: 1.0 - initial release
// ============================================================================
module tb_sc_mul_acc;

  localparam int IWID = 8;
  localparam int NCH  = 4;
  localparam int CWID = 9;

  logic                iClk = 1'b0;
  logic                iRst;
  logic                iStart;
  logic                iMode;
  logic [NCH*IWID-1:0] iWeig;
  logic [NCH-1:0]      iDbit;
  logic [NCH-1:0]      iDb_n;
  logic [NCH-1:0]      oDbit;
  logic                oValid;
  logic                oBusy;
  logic                oDone;
  logic [NCH*CWID-1:0] oCnt;

  int checks = 0;
  int errors = 0;

  sc_mul_acc #(.IWID(IWID), .NCH(NCH), .CWID(CWID)) dut (
    .iClk   (iClk),
    .iRst   (iRst),
    .iStart (iStart),
    .iMode  (iMode),
    .iWeig  (iWeig),
    .iDbit  (iDbit),
    .iDb_n  (iDb_n),
    .oDbit  (oDbit),
    .oValid (oValid),
    .oBusy  (oBusy),
    .oDone  (oDone),
    .oCnt   (oCnt)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    string                nm;
    logic                 mode;
    logic [NCH*IWID-1:0]  weig;
    logic [NCH-1:0]       dbit;
    logic [NCH-1:0]       db_n;
    logic [NCH*CWID-1:0]  exp_cnt;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  // Start edge T; returns in cycle T+1 (first RUN cycle), #1 after the edge.
  task automatic do_start(input logic mode, input logic [NCH*IWID-1:0] weig,
                          input logic [NCH-1:0] dbit, input logic [NCH-1:0] db_n);
    @(negedge iClk);
    iMode  = mode;
    iWeig  = weig;
    iDbit  = dbit;
    iDb_n  = db_n;
    iStart = 1'b1;
    @(posedge iClk);
    #1;
    iStart = 1'b0;
  endtask

  // Runs from cycle T+1 until oDone; checks latency, valid count and counts.
  task automatic run_window(input string nm, input logic [NCH*CWID-1:0] exp_cnt);
    int done_at = 0;
    int nvalid  = 0;
    chk({nm, " busy"}, 64'(oBusy), 64'd1);
    for (int k = 2; k <= 300 && done_at == 0; k++) begin
      @(posedge iClk);
      #1;
      if (oValid) nvalid++;
      if (oDone) done_at = k;
    end
    chk({nm, " done_cycle"}, 64'(done_at), 64'd257);
    chk({nm, " valid_cycles"}, 64'(nvalid), 64'd256);
    chk({nm, " cnt"}, 64'(oCnt), 64'(exp_cnt));
    @(posedge iClk);
    #1;
    chk({nm, " idle_after"}, 64'({oDone, oBusy, oValid}), 64'd0);
  endtask

  vec_t vecs[7];

  initial begin
    logic [NCH-1:0]      p;
    logic [7:0]          rng;
    int                  sums[NCH];
    int                  ndone;
    int                  first_done;
    int                  second_done;
    logic [NCH*CWID-1:0] psum;

    vecs[0] = '{"uni_w128", 1'b0, {4{8'd128}}, 4'hF, 4'h0, {4{9'd128}}};
    vecs[1] = '{"uni_edges", 1'b0, {8'd200, 8'd255, 8'd1, 8'd0}, 4'hF, 4'h0,
                {9'd200, 9'd255, 9'd1, 9'd0}};
    vecs[2] = '{"bi_w64_10", 1'b1, {4{8'd64}}, 4'hF, 4'h0, {4{9'd64}}};
    vecs[3] = '{"bi_w64_01", 1'b1, {4{8'd64}}, 4'h0, 4'hF, {4{9'd192}}};
    // Either term true: rng < 64 or ~rng >= 64 (rng <= 191) -> 192 values.
    vecs[4] = '{"bi_w64_11", 1'b1, {4{8'd64}}, 4'hF, 4'hF, {4{9'd192}}};
    vecs[5] = '{"uni_mixed", 1'b0, {4{8'd100}}, 4'b0101, 4'hA,
                {9'd0, 9'd100, 9'd0, 9'd100}};
    vecs[6] = '{"bi_w0_01", 1'b1, {4{8'd0}}, 4'h0, 4'hF, {4{9'd256}}};

    iRst = 1'b1; iStart = 1'b0; iMode = 1'b0; iWeig = '0; iDbit = '0; iDb_n = '0;
    repeat (3) @(posedge iClk);
    #1;
    chk("rst oDbit", 64'(oDbit), 64'd0);
    chk("rst oValid", 64'(oValid), 64'd0);
    chk("rst oBusy", 64'(oBusy), 64'd0);
    chk("rst oDone", 64'(oDone), 64'd0);
    chk("rst oCnt", 64'(oCnt), 64'd0);
    @(negedge iClk);
    iRst = 1'b0;

    // Table of full windows with constant bitstreams.
    for (int v = 0; v < 7; v++) begin
      do_start(vecs[v].mode, vecs[v].weig, vecs[v].dbit, vecs[v].db_n);
      run_window(vecs[v].nm, vecs[v].exp_cnt);
    end

    // iStart held high: exactly two windows, first count held until second done.
    @(negedge iClk);
    iMode = 1'b0; iWeig = {4{8'd128}}; iDbit = 4'hF; iDb_n = 4'h0; iStart = 1'b1;
    @(posedge iClk);
    #1;
    @(negedge iClk);
    iWeig = {4{8'd200}};
    ndone = 0; first_done = 0; second_done = 0;
    for (int k = 2; k <= 700; k++) begin
      @(posedge iClk);
      #1;
      if (k == 300) iStart = 1'b0;
      if (oDone) begin
        ndone++;
        if (ndone == 1) first_done = k;
        if (ndone == 2) second_done = k;
      end
      if (k == 400) chk("b2b held_cnt", 64'(oCnt), 64'({4{9'd128}}));
    end
    chk("b2b ndone", 64'(ndone), 64'd2);
    chk("b2b first_done", 64'(first_done), 64'd257);
    chk("b2b second_done", 64'(second_done), 64'd515);
    chk("b2b second_cnt", 64'(oCnt), 64'({4{9'd200}}));

    // Asynchronous reset in RUN cycle 100.
    do_start(1'b0, {4{8'd128}}, 4'hF, 4'h0);
    repeat (99) @(posedge iClk);
    @(negedge iClk);
    iRst = 1'b1;
    #1;
    chk("arst outputs", 64'({oDbit, oValid, oBusy, oDone}), 64'd0);
    chk("arst oCnt", 64'(oCnt), 64'd0);
    @(negedge iClk);
    iRst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 300; k++) begin
      @(posedge iClk);
      #1;
      if (oDone || oBusy) ndone++;
    end
    chk("arst no_done", 64'(ndone), 64'd0);
    do_start(1'b0, {8'd50, 8'd25, 8'd254, 8'd3}, 4'hF, 4'h0);
    run_window("arst rerun", {9'd50, 9'd25, 9'd254, 9'd3});

    // Random bitstream: oDbit must equal the reference product one cycle late.
    do_start(1'b0, {4{8'd170}}, 4'h0, 4'h0);
    for (int c = 0; c < NCH; c++) sums[c] = 0;
    for (int k = 0; k < 256; k++) begin
      @(negedge iClk);
      iDbit = 4'($urandom);
      rng   = rev8(8'(k));
      for (int c = 0; c < NCH; c++) p[c] = iDbit[c] & (8'd170 > rng);
      @(posedge iClk);
      #1;
      chk($sformatf("prod k=%0d", k), 64'({oValid, oDbit}), 64'({1'b1, p}));
      for (int c = 0; c < NCH; c++) sums[c] += int'(oDbit[c]);
    end
    chk("prod done", 64'(oDone), 64'd1);
    for (int c = 0; c < NCH; c++) psum[c*CWID +: CWID] = CWID'(sums[c]);
    chk("prod cnt_vs_sum", 64'(oCnt), 64'(psum));
    @(posedge iClk);
    #1;
    chk("prod idle_dbit", 64'({oValid, oDbit}), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
